// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt sequencer: state encoding,
// cause codes, default handler vectors and datapath override encodings.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HANDLER = 2'd1,
    ST_GUARD   = 2'd2
  } exc_state_e;

  localparam logic [3:0] CAUSE_NONE  = 4'd0;
  localparam logic [3:0] CAUSE_ILLOP = 4'd1;
  localparam logic [3:0] CAUSE_IRQ0  = 4'd2;

  localparam logic [31:0] DFLT_ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] DFLT_XADR_VEC  = 32'h8000_0008;

  // Return address register ($26) selected by RegDst=XP.
  localparam logic [4:0] XP_REG = 5'd26;

  localparam logic [2:0] PCSRC_PLUS4  = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_ILLOP  = 3'd3;
  localparam logic [2:0] PCSRC_XADR   = 3'd4;

  function automatic logic [3:0] irq_cause(input logic [3:0] idx);
    return CAUSE_IRQ0 + idx;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set pending bit wins; outputs a one-hot
// grant, the winning index and an any-pending flag. Purely combinational.
module irq_prio_enc #(
  parameter int N_IRQ = 2,
  parameter int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic [N_IRQ-1:0] i_pending,
  output logic [N_IRQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    // Walking from the top down lets the lowest set bit overwrite last.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (i_pending[i]) begin
        o_grant    = '0;
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
      end
    end
  end

  assign o_any = |i_pending;

endmodule

// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer for the single-cycle MIPS datapath.
// Optional feature macro: EXC_STATS_EN (saturating taken-event counter).
module exc_sequencer
  import exc_pkg::*;
#(
  parameter int          N_IRQ     = 2,
  parameter logic [31:0] ILLOP_VEC = DFLT_ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = DFLT_XADR_VEC,
  parameter int          GUARD     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [31:0]      new_pc,
  input  logic             illop,
  input  logic             irq_en,
  input  logic [N_IRQ-1:0] irq_req,
  output logic [N_IRQ-1:0] irq_ack,
  output logic             take_exc,
  output logic [31:0]      exc_vector,
  output logic [31:0]      exc_ret_addr,
  output logic [3:0]       exc_cause,
  output logic             in_handler,
  output logic             double_fault,
  output logic [15:0]      exc_count
);

  localparam int         IDX_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [3:0] GUARD_INIT = 4'(GUARD - 1);

  exc_state_e       r_state, w_state_nxt;
  logic [3:0]       r_guard_cnt, w_guard_nxt;
  logic [N_IRQ-1:0] r_pending, r_req_q;
  logic [3:0]       r_cause;
  logic             r_double_fault;

  logic [N_IRQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_any_pending;
  logic             w_user;
  logic             w_take_irq;
  logic             w_take_ill;

  irq_prio_enc #(
    .N_IRQ (N_IRQ),
    .IDX_W (IDX_W)
  ) u_prio (
    .i_pending (r_pending),
    .o_grant   (w_grant),
    .o_idx     (w_grant_idx),
    .o_any     (w_any_pending)
  );

  // Interrupts need a clean user-mode RUN; illop is also honoured in GUARD.
  assign w_user     = ~pc[31];
  assign w_take_irq = (r_state == ST_RUN) && w_user && irq_en && w_any_pending;
  assign w_take_ill = !w_take_irq && (r_state != ST_HANDLER) && w_user && illop;

  assign take_exc     = w_take_irq | w_take_ill;
  assign irq_ack      = w_take_irq ? w_grant : '0;
  assign exc_vector   = w_take_irq ? XADR_VEC : (w_take_ill ? ILLOP_VEC : 32'h0);
  assign exc_ret_addr = w_take_irq ? pc : (w_take_ill ? new_pc : 32'h0);
  assign exc_cause    = r_cause;
  assign in_handler   = (r_state == ST_HANDLER);
  assign double_fault = r_double_fault;

  always_comb begin
    w_state_nxt = r_state;
    w_guard_nxt = r_guard_cnt;
    unique case (r_state)
      ST_RUN: begin
        if (take_exc) w_state_nxt = ST_HANDLER;
      end
      ST_HANDLER: begin
        // Handler returned via jr $26 once the supervisor bit drops.
        if (w_user) begin
          w_state_nxt = ST_GUARD;
          w_guard_nxt = GUARD_INIT;
        end
      end
      ST_GUARD: begin
        if (take_exc) begin
          w_state_nxt = ST_HANDLER;
        end else if (r_guard_cnt == 4'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_guard_nxt = r_guard_cnt - 4'd1;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_RUN;
      r_guard_cnt    <= 4'd0;
      r_pending      <= '0;
      r_req_q        <= '0;
      r_cause        <= CAUSE_NONE;
      r_double_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_guard_cnt <= w_guard_nxt;
      r_req_q     <= irq_req;
      // A fresh edge on the ack cycle wins over the clear.
      r_pending   <= (r_pending & ~irq_ack) | (irq_req & ~r_req_q);
      if (take_exc) begin
        r_cause <= w_take_irq ? irq_cause(4'(w_grant_idx)) : CAUSE_ILLOP;
      end
      if ((r_state == ST_HANDLER) && illop && pc[31]) begin
        r_double_fault <= 1'b1;
      end
    end
  end

`ifdef EXC_STATS_EN
  logic [15:0] r_exc_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exc_count <= 16'h0;
    end else if (take_exc && (r_exc_count != 16'hFFFF)) begin
      r_exc_count <= r_exc_count + 16'h1;
    end
  end

  assign exc_count = r_exc_count;
`else
  assign exc_count = 16'h0;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: a driver feeds directed and random
// cycles through a behavioural model; a monitor pops and compares.
module tb_exc_sequencer;

  localparam int N     = 2;
  localparam int GUARD = 2;
`ifdef EXC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc, new_pc;
  logic          illop, irq_en;
  logic [N-1:0]  irq_req, irq_ack;
  logic          take_exc, in_handler, double_fault;
  logic [31:0]   exc_vector, exc_ret_addr;
  logic [3:0]    exc_cause;
  logic [15:0]   exc_count;

  exc_sequencer #(
    .N_IRQ     (N),
    .ILLOP_VEC (32'h8000_0004),
    .XADR_VEC  (32'h8000_0008),
    .GUARD     (GUARD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .new_pc       (new_pc),
    .illop        (illop),
    .irq_en       (irq_en),
    .irq_req      (irq_req),
    .irq_ack      (irq_ack),
    .take_exc     (take_exc),
    .exc_vector   (exc_vector),
    .exc_ret_addr (exc_ret_addr),
    .exc_cause    (exc_cause),
    .in_handler   (in_handler),
    .double_fault (double_fault),
    .exc_count    (exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic         take;
    logic [N-1:0] ack;
    logic [3:0]   cause;
    logic         hand;
    logic         df;
    logic [15:0]  cnt;
  } st_t;

  typedef struct {
    int          cyc;
    logic [31:0] vec;
    logic [31:0] ret;
  } ev_t;

  st_t sq[$];
  ev_t evq[$];

  int checks   = 0;
  int failures = 0;
  int cur_cyc  = 0;
  int cyc      = 0;

  // Behavioural model: handler flag, count of user cycles with irqs still
  // blocked after a return, latched requests, last cause, sticky fault.
  bit         m_hand;
  int         m_block;
  bit [N-1:0] m_pend, m_prev;
  logic [3:0] m_cause;
  bit         m_df;
  int         m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cur_cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hand  = 1'b0;
    m_block = 0;
    m_pend  = '0;
    m_prev  = '0;
    m_cause = 4'd0;
    m_df    = 1'b0;
    m_count = 0;
  endtask

  task automatic cycle(input logic [31:0] p, input logic il, input logic en, input logic [N-1:0] rq);
    st_t          s;
    ev_t          e;
    int           lowest;
    bit           t_irq, t_ill;
    logic [N-1:0] ack;
    @(posedge clk);
    #1;
    pc = p; new_pc = p + 32'd4; illop = il; irq_en = en; irq_req = rq;
    lowest = -1;
    for (int i = 0; i < N; i++) if (m_pend[i] && lowest < 0) lowest = i;
    t_irq = !m_hand && (m_block == 0) && !p[31] && en && (lowest >= 0);
    t_ill = !t_irq && !m_hand && !p[31] && il;
    ack = '0;
    if (t_irq) ack[lowest] = 1'b1;
    s.cyc = cyc; s.take = t_irq || t_ill; s.ack = ack; s.cause = m_cause;
    s.hand = m_hand; s.df = m_df; s.cnt = STATS ? 16'(m_count) : 16'h0;
    sq.push_back(s);
    if (t_irq || t_ill) begin
      e.cyc = cyc;
      e.vec = t_irq ? 32'h8000_0008 : 32'h8000_0004;
      e.ret = t_irq ? p : p + 32'd4;
      evq.push_back(e);
    end
    m_pend = (m_pend & ~ack) | (rq & ~m_prev);
    m_prev = rq;
    if (t_irq || t_ill) begin
      m_hand  = 1'b1;
      m_block = 0;
      m_cause = t_irq ? 4'(2 + lowest) : 4'd1;
      if (m_count < 65535) m_count++;
    end else if (m_hand) begin
      if (il && p[31]) m_df = 1'b1;
      if (!p[31]) begin
        m_hand  = 1'b0;
        m_block = GUARD;
      end
    end else if (m_block > 0) begin
      m_block--;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    pc = 32'h0000_0100; new_pc = 32'h0000_0104; illop = 1'b0; irq_en = 1'b1; irq_req = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor
  initial begin
    st_t s;
    ev_t e;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        cur_cyc = s.cyc;
        check("take_exc", 32'(take_exc), 32'(s.take));
        check("irq_ack", 32'(irq_ack), 32'(s.ack));
        check("exc_cause", 32'(exc_cause), 32'(s.cause));
        check("in_handler", 32'(in_handler), 32'(s.hand));
        check("double_fault", 32'(double_fault), 32'(s.df));
        check("exc_count", 32'(exc_count), 32'(s.cnt));
        if (take_exc === 1'b1) begin
          check("take_expected", 32'(evq.size() > 0), 32'd1);
          if (evq.size() > 0) begin
            e = evq.pop_front();
            check("take_cycle", 32'(s.cyc), 32'(e.cyc));
            check("exc_vector", exc_vector, e.vec);
            check("exc_ret_addr", exc_ret_addr, e.ret);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cur_cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]  p;
    logic         il, en;
    logic [N-1:0] rq;
    reset = 1'b0;
    pc = 32'h0000_0100; new_pc = 32'h0000_0104; illop = 1'b0; irq_en = 1'b1; irq_req = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Quiet user code after reset
    repeat (10) cycle(32'h0000_0100, 1'b0, 1'b1, 2'b00);

    // Two simultaneous request edges: irq0 first, irq1 after return + guard
    cycle(32'h0000_0040, 1'b0, 1'b1, 2'b11);
    cycle(32'h0000_0040, 1'b0, 1'b1, 2'b11);
    repeat (3) cycle(32'h8000_0008, 1'b0, 1'b1, 2'b11);
    cycle(32'h8000_000C, 1'b0, 1'b1, 2'b00);
    cycle(32'h0000_0040, 1'b0, 1'b1, 2'b00);
    cycle(32'h0000_0044, 1'b0, 1'b1, 2'b00);
    cycle(32'h0000_0048, 1'b0, 1'b1, 2'b00);
    cycle(32'h0000_004C, 1'b0, 1'b1, 2'b00);
    cycle(32'h8000_0008, 1'b0, 1'b1, 2'b00);
    cycle(32'h0000_004C, 1'b0, 1'b1, 2'b00);
    repeat (4) cycle(32'h0000_0050, 1'b0, 1'b1, 2'b00);

    // Illegal opcode, then double fault inside the handler
    cycle(32'h0000_0080, 1'b1, 1'b1, 2'b00);
    cycle(32'h8000_0004, 1'b0, 1'b1, 2'b00);
    cycle(32'h8000_0010, 1'b1, 1'b1, 2'b00);
    cycle(32'h8000_0014, 1'b0, 1'b1, 2'b00);
    cycle(32'h0000_0084, 1'b0, 1'b1, 2'b00);

    // Request edge during guard: masked, then taken on first RUN cycle
    cycle(32'h0000_0088, 1'b0, 1'b1, 2'b01);
    cycle(32'h0000_008C, 1'b0, 1'b1, 2'b01);
    cycle(32'h0000_0090, 1'b0, 1'b1, 2'b01);

    // Reset mid-handler with irq1 pending
    cycle(32'h8000_0008, 1'b0, 1'b1, 2'b01);
    cycle(32'h8000_000C, 1'b0, 1'b1, 2'b11);
    cycle(32'h8000_0010, 1'b0, 1'b1, 2'b11);
    do_reset();
    repeat (5) cycle(32'h0000_0100, 1'b0, 1'b1, 2'b00);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) do_reset();
      if (m_hand) begin
        if ($urandom_range(3) == 0) p = {1'b0, 21'h0, 8'($urandom_range(255)), 2'b00};
        else                         p = {1'b1, 21'h0, 8'($urandom_range(255)), 2'b00};
      end else begin
        p = {($urandom_range(15) == 0), 21'h0, 8'($urandom_range(255)), 2'b00};
      end
      il = ($urandom_range(9) == 0);
      if (p[31] && !m_hand) il = 1'b0;
      en = ($urandom_range(7) != 0);
      rq = irq_req;
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) rq[i] = ~rq[i];
      cycle(p, il, en, rq);
    end

    @(negedge clk);
    #1;
    check("event_queue_drained", 32'(evq.size()), 32'd0);
    check("status_queue_drained", 32'(sq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
